// File: rtl/pong_score_controller.sv
// Pong score controller: detects paddle hits and goals from the ball and paddle
// positions, keeps both scores, and sequences serve / play / point / game-over.
// Everything advances once per game_clk tick and all outputs are registered.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | power-up, ball held at serve position, waiting for start
// ST_SERVE | ball held for SERVE_TICKS ticks before play resumes
// ST_PLAY  | ball live, hits and goals are evaluated
// ST_POINT | one tick after a goal, decides next serve or game over
// ST_OVER  | a player reached WIN_SCORE, scores frozen until start

module pong_score_controller #(
    parameter logic [9:0] LPADDLE_X   = 10'd20,
    parameter logic [9:0] RPADDLE_X   = 10'd620,
    parameter logic [9:0] PADDLE_H    = 10'd64,
    parameter logic [9:0] GOAL_MARGIN = 10'd4,
    parameter logic [7:0] SERVE_TICKS = 8'd60,
    parameter logic [3:0] WIN_SCORE   = 4'd9
) (
    input  logic       game_clk,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] x_ball,
    input  logic [9:0] y_ball,
    input  logic       x_ball_dir,
    input  logic [4:0] width_ball,
    input  logic [4:0] height_ball,
    input  logic [9:0] x_lwall,
    input  logic [9:0] x_rwall,
    input  logic [9:0] y_lpaddle,
    input  logic [9:0] y_rpaddle,
    output logic       ball_reset,
    output logic       serve_dir,
    output logic       lpaddle_hit,
    output logic       rpaddle_hit,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over,
    output logic       winner
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] serve_cnt_q, serve_cnt_d;
    logic       arm_l_q, arm_l_d;
    logic       arm_r_q, arm_r_d;
    logic       ball_reset_q, ball_reset_d;
    logic       serve_dir_q, serve_dir_d;
    logic       lpaddle_hit_q, lpaddle_hit_d;
    logic       rpaddle_hit_q, rpaddle_hit_d;
    logic [3:0] score_l_q, score_l_d;
    logic [3:0] score_r_q, score_r_d;
    logic       game_over_q, game_over_d;
    logic       winner_q, winner_d;

    // 11-bit zero-extended operands so edge sums never wrap
    logic [10:0] x_ball_e, y_ball_e, width_e, height_e;
    logic [10:0] ball_right_e, ball_bottom_e;
    logic        in_play;
    logic        l_ovl, r_ovl;
    logic        l_hit_c, r_hit_c, l_goal_c, r_goal_c;

    assign x_ball_e      = {1'b0, x_ball};
    assign y_ball_e      = {1'b0, y_ball};
    assign width_e       = {6'b0, width_ball};
    assign height_e      = {6'b0, height_ball};
    assign ball_right_e  = x_ball_e + width_e;
    assign ball_bottom_e = y_ball_e + height_e;
    assign in_play       = (state_q == ST_PLAY);

    assign l_ovl = (ball_bottom_e >= {1'b0, y_lpaddle}) &&
                   (y_ball_e <= ({1'b0, y_lpaddle} + {1'b0, PADDLE_H}));
    assign r_ovl = (ball_bottom_e >= {1'b0, y_rpaddle}) &&
                   (y_ball_e <= ({1'b0, y_rpaddle} + {1'b0, PADDLE_H}));

    // Hit gated by PLAY, so hit pulses are inherently zero in every other state
    assign l_hit_c  = in_play && !x_ball_dir && (x_ball_e <= {1'b0, LPADDLE_X}) && l_ovl && arm_l_q;
    assign r_hit_c  = in_play && x_ball_dir && (ball_right_e >= {1'b0, RPADDLE_X}) && r_ovl && arm_r_q;
    assign l_goal_c = in_play && !x_ball_dir &&
                      (x_ball_e <= ({1'b0, x_lwall} + {1'b0, GOAL_MARGIN})) && !l_hit_c;
    assign r_goal_c = in_play && x_ball_dir &&
                      ((ball_right_e + {1'b0, GOAL_MARGIN}) >= {1'b0, x_rwall}) && !r_hit_c;

    // Next-state, scoring, arming and output computation
    always_comb begin
        state_d       = state_q;
        serve_cnt_d   = serve_cnt_q;
        serve_dir_d   = serve_dir_q;
        score_l_d     = score_l_q;
        score_r_d     = score_r_q;
        game_over_d   = game_over_q;
        winner_d      = winner_q;
        lpaddle_hit_d = l_hit_c;
        rpaddle_hit_d = r_hit_c;

        // One pulse per approach: disarm on a hit, re-arm once the ball turns away
        arm_l_d = arm_l_q;
        arm_r_d = arm_r_q;
        if (l_hit_c) begin
            arm_l_d = 1'b0;
        end else if (x_ball_dir) begin
            arm_l_d = 1'b1;
        end
        if (r_hit_c) begin
            arm_r_d = 1'b0;
        end else if (!x_ball_dir) begin
            arm_r_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_SERVE;
                    serve_cnt_d = 8'd0;
                end
            end
            ST_SERVE: begin
                if (serve_cnt_q == (SERVE_TICKS - 8'd1)) begin
                    state_d     = ST_PLAY;
                    serve_cnt_d = 8'd0;
                end else begin
                    serve_cnt_d = serve_cnt_q + 8'd1;
                end
            end
            ST_PLAY: begin
                if (l_goal_c) begin
                    if (score_r_q < WIN_SCORE) begin
                        score_r_d = score_r_q + 4'd1;
                    end
                    serve_dir_d = 1'b0;
                    state_d     = ST_POINT;
                end else if (r_goal_c) begin
                    if (score_l_q < WIN_SCORE) begin
                        score_l_d = score_l_q + 4'd1;
                    end
                    serve_dir_d = 1'b1;
                    state_d     = ST_POINT;
                end
            end
            ST_POINT: begin
                arm_l_d = 1'b1;
                arm_r_d = 1'b1;
                if ((score_l_q == WIN_SCORE) || (score_r_q == WIN_SCORE)) begin
                    state_d     = ST_OVER;
                    game_over_d = 1'b1;
                    winner_d    = (score_r_q == WIN_SCORE);
                end else begin
                    state_d     = ST_SERVE;
                    serve_cnt_d = 8'd0;
                end
            end
            ST_OVER: begin
                if (start) begin
                    score_l_d   = 4'd0;
                    score_r_d   = 4'd0;
                    winner_d    = 1'b0;
                    game_over_d = 1'b0;
                    state_d     = ST_SERVE;
                    serve_cnt_d = 8'd0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                serve_cnt_d = 8'd0;
            end
        endcase

        // Ball is only released while the next state is PLAY
        ball_reset_d = (state_d != ST_PLAY);
    end

    // State and output registers, synchronous reset has top priority
    always_ff @(posedge game_clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            serve_cnt_q   <= 8'd0;
            arm_l_q       <= 1'b1;
            arm_r_q       <= 1'b1;
            ball_reset_q  <= 1'b1;
            serve_dir_q   <= 1'b1;
            lpaddle_hit_q <= 1'b0;
            rpaddle_hit_q <= 1'b0;
            score_l_q     <= 4'd0;
            score_r_q     <= 4'd0;
            game_over_q   <= 1'b0;
            winner_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            serve_cnt_q   <= serve_cnt_d;
            arm_l_q       <= arm_l_d;
            arm_r_q       <= arm_r_d;
            ball_reset_q  <= ball_reset_d;
            serve_dir_q   <= serve_dir_d;
            lpaddle_hit_q <= lpaddle_hit_d;
            rpaddle_hit_q <= rpaddle_hit_d;
            score_l_q     <= score_l_d;
            score_r_q     <= score_r_d;
            game_over_q   <= game_over_d;
            winner_q      <= winner_d;
        end
    end

    assign ball_reset  = ball_reset_q;
    assign serve_dir   = serve_dir_q;
    assign lpaddle_hit = lpaddle_hit_q;
    assign rpaddle_hit = rpaddle_hit_q;
    assign score_l     = score_l_q;
    assign score_r     = score_r_q;
    assign game_over   = game_over_q;
    assign winner      = winner_q;

endmodule

// File: tb/tb_pong_score_controller.sv
// Self-checking bench for pong_score_controller: a table of per-tick PLAY
// vectors for hit detection, plus hand-written serve/goal/game-over/reset runs.

module tb_pong_score_controller;

    logic       game_clk = 1'b0;
    logic       reset, start;
    logic [9:0] x_ball, y_ball, x_lwall, x_rwall, y_lpaddle, y_rpaddle;
    logic       x_ball_dir;
    logic [4:0] width_ball, height_ball;
    logic       ball_reset, serve_dir, lpaddle_hit, rpaddle_hit, game_over, winner;
    logic [3:0] score_l, score_r;

    pong_score_controller dut (
        .game_clk    (game_clk),
        .reset       (reset),
        .start       (start),
        .x_ball      (x_ball),
        .y_ball      (y_ball),
        .x_ball_dir  (x_ball_dir),
        .width_ball  (width_ball),
        .height_ball (height_ball),
        .x_lwall     (x_lwall),
        .x_rwall     (x_rwall),
        .y_lpaddle   (y_lpaddle),
        .y_rpaddle   (y_rpaddle),
        .ball_reset  (ball_reset),
        .serve_dir   (serve_dir),
        .lpaddle_hit (lpaddle_hit),
        .rpaddle_hit (rpaddle_hit),
        .score_l     (score_l),
        .score_r     (score_r),
        .game_over   (game_over),
        .winner      (winner)
    );

    always #5 game_clk = ~game_clk;

    typedef struct packed {
        logic       br;
        logic       sd;
        logic       lh;
        logic       rh;
        logic [3:0] sl;
        logic [3:0] sr;
        logic       go;
        logic       w;
    } out_t;

    typedef struct {
        string name;
        out_t  e;
    } sb_t;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       dir;
        logic [4:0] h;
        logic [9:0] ylp;
        logic [9:0] yrp;
        logic       lh;
        logic       rh;
    } vec_t;

    sb_t  sb_q[$];
    vec_t vecs[26];
    int   total = 0;
    int   bad   = 0;

    function automatic out_t mk(int br, int sd, int lh, int rh, int sl, int sr, int go, int w);
        out_t o;
        o.br = 1'(br); o.sd = 1'(sd); o.lh = 1'(lh); o.rh = 1'(rh);
        o.sl = 4'(sl); o.sr = 4'(sr); o.go = 1'(go); o.w = 1'(w);
        return o;
    endfunction

    function automatic vec_t mkv(int x, int y, int dir, int h, int ylp, int yrp, int lh, int rh);
        vec_t v;
        v.x = 10'(x); v.y = 10'(y); v.dir = 1'(dir); v.h = 5'(h);
        v.ylp = 10'(ylp); v.yrp = 10'(yrp); v.lh = 1'(lh); v.rh = 1'(rh);
        return v;
    endfunction

    function automatic out_t get_out();
        out_t o;
        o.br = ball_reset; o.sd = serve_dir; o.lh = lpaddle_hit; o.rh = rpaddle_hit;
        o.sl = score_l; o.sr = score_r; o.go = game_over; o.w = winner;
        return o;
    endfunction

    task automatic tick();
        @(posedge game_clk);
        #1;
    endtask

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Push the expectation, let one edge pass, then pop and compare
    task automatic expect_next(string name, out_t e);
        sb_t  s;
        out_t a;
        s.name = name;
        s.e    = e;
        sb_q.push_back(s);
        tick();
        s = sb_q.pop_front();
        a = get_out();
        total++;
        if (a !== s.e) begin
            bad++;
            $display("FAIL %s: got br=%0d sd=%0d lh=%0d rh=%0d sl=%0d sr=%0d go=%0d w=%0d want br=%0d sd=%0d lh=%0d rh=%0d sl=%0d sr=%0d go=%0d w=%0d",
                     s.name, a.br, a.sd, a.lh, a.rh, a.sl, a.sr, a.go, a.w,
                     s.e.br, s.e.sd, s.e.lh, s.e.rh, s.e.sl, s.e.sr, s.e.go, s.e.w);
        end
    endtask

    // Counts samples with ball_reset high, starting from the sample after serve entry
    task automatic serve_len(string name);
        int n = 0;
        while (ball_reset === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        chk(name, n, 60);
    endtask

    task automatic set_neutral();
        x_ball = 10'd300; y_ball = 10'd100; x_ball_dir = 1'b0;
        width_ball = 5'd8; height_ball = 5'd8;
        x_lwall = 10'd0; x_rwall = 10'd639;
        y_lpaddle = 10'd300; y_rpaddle = 10'd300;
    endtask

    task automatic set_lgoal();
        set_neutral();
        x_ball = 10'd3;
    endtask

    task automatic set_rgoal();
        set_neutral();
        x_ball_dir = 1'b1;
        x_ball = 10'd629;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        out_t rst_o;
        rst_o = mk(1, 1, 0, 0, 0, 0, 0, 0);

        vecs[0]  = mkv(18, 100, 0, 8, 80, 300, 1, 0);
        vecs[1]  = mkv(18, 100, 0, 8, 80, 300, 0, 0);
        vecs[2]  = mkv(18, 100, 0, 8, 80, 300, 0, 0);
        vecs[3]  = mkv(18, 100, 0, 8, 80, 300, 0, 0);
        vecs[4]  = mkv(18, 100, 0, 8, 80, 300, 0, 0);
        vecs[5]  = mkv(300, 100, 1, 8, 80, 300, 0, 0);
        vecs[6]  = mkv(18, 100, 0, 8, 80, 300, 1, 0);
        vecs[7]  = mkv(300, 100, 1, 8, 80, 300, 0, 0);
        vecs[8]  = mkv(615, 100, 1, 8, 80, 80, 0, 1);
        vecs[9]  = mkv(615, 100, 1, 8, 80, 80, 0, 0);
        vecs[10] = mkv(300, 100, 0, 8, 300, 300, 0, 0);
        vecs[11] = mkv(21, 100, 0, 8, 80, 300, 0, 0);
        vecs[12] = mkv(20, 72, 0, 8, 80, 300, 1, 0);
        vecs[13] = mkv(300, 100, 1, 8, 80, 300, 0, 0);
        vecs[14] = mkv(20, 144, 0, 8, 80, 300, 1, 0);
        vecs[15] = mkv(300, 100, 1, 8, 80, 300, 0, 0);
        vecs[16] = mkv(20, 145, 0, 8, 80, 300, 0, 0);
        vecs[17] = mkv(20, 71, 0, 8, 80, 300, 0, 0);
        vecs[18] = mkv(10, 1020, 0, 8, 1000, 300, 1, 0);
        vecs[19] = mkv(300, 100, 1, 8, 300, 300, 0, 0);
        vecs[20] = mkv(3, 100, 0, 8, 80, 300, 1, 0);
        vecs[21] = mkv(300, 100, 1, 8, 300, 300, 0, 0);
        vecs[22] = mkv(18, 100, 1, 8, 80, 300, 0, 0);
        vecs[23] = mkv(612, 100, 1, 8, 300, 80, 0, 1);
        vecs[24] = mkv(300, 100, 0, 8, 300, 80, 0, 0);
        vecs[25] = mkv(611, 100, 1, 8, 300, 80, 0, 0);

        set_neutral();
        reset = 1'b1;
        start = 1'b0;
        tick();
        expect_next("reset_values", rst_o);
        reset = 1'b0;
        expect_next("idle_hold", rst_o);
        set_lgoal();
        expect_next("idle_no_score", rst_o);
        set_neutral();
        start = 1'b1;
        expect_next("start_to_serve", rst_o);
        start = 1'b0;
        serve_len("serve_len_first");

        // PLAY: hit detection table, start held high to confirm it is ignored
        start = 1'b1;
        for (int i = 0; i < 26; i++) begin
            x_ball = vecs[i].x; y_ball = vecs[i].y; x_ball_dir = vecs[i].dir;
            height_ball = vecs[i].h; y_lpaddle = vecs[i].ylp; y_rpaddle = vecs[i].yrp;
            expect_next($sformatf("vec_%0d", i), mk(0, 1, vecs[i].lh, vecs[i].rh, 0, 0, 0, 0));
        end
        start = 1'b0;

        // Left goal, then goal inputs held through POINT/SERVE must not score
        set_lgoal();
        expect_next("lgoal", mk(1, 0, 0, 0, 0, 1, 0, 0));
        expect_next("lgoal_point", mk(1, 0, 0, 0, 0, 1, 0, 0));
        serve_len("serve_len_after_lgoal");
        chk("sr_held_in_serve", int'(score_r), 1);
        set_neutral();

        // Right goals up to the winning score
        for (int k = 1; k <= 9; k++) begin
            set_rgoal();
            expect_next($sformatf("rgoal_%0d", k), mk(1, 1, 0, 0, k, 1, 0, 0));
            set_neutral();
            if (k < 9) begin
                expect_next($sformatf("rpoint_%0d", k), mk(1, 1, 0, 0, k, 1, 0, 0));
                serve_len($sformatf("serve_len_r%0d", k));
            end else begin
                expect_next("game_over", mk(1, 1, 0, 0, 9, 1, 1, 0));
            end
        end

        // Scores frozen in GAME_OVER
        for (int k = 0; k < 3; k++) begin
            if (k == 1) set_lgoal(); else set_rgoal();
            expect_next($sformatf("over_frozen_%0d", k), mk(1, 1, 0, 0, 9, 1, 1, 0));
        end

        // Restart from GAME_OVER
        set_neutral();
        start = 1'b1;
        expect_next("restart", mk(1, 1, 0, 0, 0, 0, 0, 0));
        start = 1'b0;

        // Reset in the middle of a serve
        for (int k = 0; k < 29; k++) tick();
        chk("mid_serve_br", int'(ball_reset), 1);
        reset = 1'b1;
        expect_next("reset_mid_serve", rst_o);
        reset = 1'b0;
        set_lgoal();
        expect_next("idle_after_serve_reset", rst_o);
        set_neutral();
        start = 1'b1;
        expect_next("start_after_reset", rst_o);
        start = 1'b0;
        serve_len("serve_len_after_reset");

        // Three left goals, then reset in the middle of play
        for (int k = 1; k <= 3; k++) begin
            set_lgoal();
            expect_next($sformatf("lgoal_b%0d", k), mk(1, 0, 0, 0, 0, k, 0, 0));
            set_neutral();
            expect_next($sformatf("lpoint_b%0d", k), mk(1, 0, 0, 0, 0, k, 0, 0));
            serve_len($sformatf("serve_len_b%0d", k));
        end
        chk("play_before_reset_br", int'(ball_reset), 0);
        reset = 1'b1;
        expect_next("reset_mid_play", rst_o);
        reset = 1'b0;
        set_lgoal();
        expect_next("idle_after_play_reset", rst_o);
        expect_next("idle_after_play_reset_2", rst_o);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
